// File: rtl/bug_pkg.sv
// Shared constants and helpers for the BugFest bug lane.
package bug_pkg;

    localparam int W_DEFAULT = 15;

    // Vertical walking direction of a bug.
    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Clamp a vertical coordinate into the inclusive range [lo, hi].
    function automatic logic [31:0] clamp_v(input logic [31:0] v,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
        logic [31:0] r;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Number of set bits in an 8-bit vector (lane holds at most 8 slots).
    function automatic logic [3:0] popcount(input logic [7:0] bits);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, bits[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/bug_lane_if.sv
// Control and sprite-position bundle between the game logic and the bug lane.
interface bug_lane_if #(
    parameter int NUM_BUGS = 4,
    parameter int W        = 15
);
    logic                  INIT;
    logic                  Frame;
    logic                  leftEN;
    logic                  spawn;
    logic [W-1:0]          spawnV;
    logic [NUM_BUGS-1:0]   kill;
    logic [NUM_BUGS*W-1:0] BugH;
    logic [NUM_BUGS*W-1:0] BugV;
    logic [NUM_BUGS-1:0]   active;
    logic                  escaped;
    logic                  overflow;
    logic [3:0]            live_count;

    modport master (
        output INIT, Frame, leftEN, spawn, spawnV, kill,
        input  BugH, BugV, active, escaped, overflow, live_count
    );

    modport slave (
        input  INIT, Frame, leftEN, spawn, spawnV, kill,
        output BugH, BugV, active, escaped, overflow, live_count
    );
endinterface

// File: rtl/bug_slot.sv
// One bug slot: position, bounce direction and occupancy with their update rules.
module bug_slot
    import bug_pkg::*;
#(
    parameter int W       = W_DEFAULT,
    parameter int H_START = 640,
    parameter int H_STEP  = 1,
    parameter int V_MIN   = 40,
    parameter int V_MAX   = 220,
    parameter int V_STEP  = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic         load,
    input  logic [W-1:0] loadv,
    input  logic         kill,
    input  logic         frame,
    input  logic         lefte,
    output logic [W-1:0] h,
    output logic [W-1:0] v,
    output logic         active,
    output logic         act_next,
    output logic         escape
);

    localparam int WX = W + 1;
    localparam logic [W:0] HSTEP_X = WX'(H_STEP);
    localparam logic [W:0] VMIN_X  = WX'(V_MIN);
    localparam logic [W:0] VMAX_X  = WX'(V_MAX);
    localparam logic [W:0] VSTEP_X = WX'(V_STEP);

    logic [W-1:0] h_r, h_d;
    logic [W-1:0] v_r, v_d;
    logic         dir_r, dir_d;
    logic         act_r, act_d;
    logic         esc_s;
    logic [W:0]   h_x_s, v_x_s;

    // Bounds tests are done one bit wider so the step can never wrap.
    assign h_x_s = {1'b0, h_r};
    assign v_x_s = {1'b0, v_r};

    // Next-state rules: init, then kill, then spawn load, then frame motion.
    always_comb begin
        h_d   = h_r;
        v_d   = v_r;
        dir_d = dir_r;
        act_d = act_r;
        esc_s = 1'b0;
        if (init) begin
            h_d   = '0;
            v_d   = '0;
            dir_d = DIR_DOWN;
            act_d = 1'b0;
        end else if (kill) begin
            act_d = 1'b0;
        end else if (load) begin
            h_d   = W'(H_START);
            v_d   = W'(clamp_v(32'(loadv), 32'(V_MIN), 32'(V_MAX)));
            dir_d = DIR_DOWN;
            act_d = 1'b1;
        end else if (frame && act_r) begin
            if (lefte) begin
                if (h_x_s < HSTEP_X) begin
                    act_d = 1'b0;
                    esc_s = 1'b1;
                end else begin
                    h_d = h_r - W'(H_STEP);
                end
            end else begin
                h_d = h_r;
            end
            if (dir_r == DIR_DOWN) begin
                if ((v_x_s + VSTEP_X) > VMAX_X) begin
                    v_d   = W'(V_MAX);
                    dir_d = DIR_UP;
                end else begin
                    v_d = v_r + W'(V_STEP);
                end
            end else begin
                if (v_x_s < (VMIN_X + VSTEP_X)) begin
                    v_d   = W'(V_MIN);
                    dir_d = DIR_DOWN;
                end else begin
                    v_d = v_r - W'(V_STEP);
                end
            end
        end else begin
            act_d = act_r;
        end
    end

    // Slot state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_r   <= '0;
            v_r   <= '0;
            dir_r <= DIR_DOWN;
            act_r <= 1'b0;
        end else begin
            h_r   <= h_d;
            v_r   <= v_d;
            dir_r <= dir_d;
            act_r <= act_d;
        end
    end

    assign h        = h_r;
    assign v        = v_r;
    assign active   = act_r;
    assign act_next = act_d;
    assign escape   = esc_s;

endmodule

// File: rtl/bug_lane.sv
// Multi-slot bug position engine: spawn allocation, per-slot motion and status pulses.
module bug_lane
    import bug_pkg::*;
#(
    parameter int NUM_BUGS = 4,
    parameter int W        = W_DEFAULT,
    parameter int H_START  = 640,
    parameter int H_STEP   = 1,
    parameter int V_MIN    = 40,
    parameter int V_MAX    = 220,
    parameter int V_STEP   = 1,
    parameter int V_SHIFT  = 1
) (
    input logic       clk,
    input logic       rst,
    bug_lane_if.slave bus
);

    logic [NUM_BUGS-1:0] act_s;
    logic [NUM_BUGS-1:0] act_next_s;
    logic [NUM_BUGS-1:0] esc_s;
    logic [NUM_BUGS-1:0] load_s;
    logic [W-1:0]        h_s [NUM_BUGS];
    logic [W-1:0]        v_s [NUM_BUGS];
    logic                any_free_s;
    logic [7:0]          act_pad_s;
    logic                escaped_r;
    logic                overflow_r;
    logic [3:0]          live_count_r;

    // Lowest-index free slot; a slot being killed this cycle is not free yet.
    always_comb begin
        load_s     = '0;
        any_free_s = 1'b0;
        for (int i = 0; i < NUM_BUGS; i++) begin
            if (!any_free_s && !act_s[i] && !bus.kill[i]) begin
                any_free_s = 1'b1;
                load_s[i]  = bus.spawn;
            end else begin
                load_s[i] = 1'b0;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_BUGS; g++) begin : g_slot
            bug_slot #(
                .W       (W),
                .H_START (H_START),
                .H_STEP  (H_STEP),
                .V_MIN   (V_MIN),
                .V_MAX   (V_MAX),
                .V_STEP  (V_STEP)
            ) u_slot (
                .clk      (clk),
                .rst      (rst),
                .init     (bus.INIT),
                .load     (load_s[g]),
                .loadv    (bus.spawnV),
                .kill     (bus.kill[g]),
                .frame    (bus.Frame),
                .lefte    (bus.leftEN),
                .h        (h_s[g]),
                .v        (v_s[g]),
                .active   (act_s[g]),
                .act_next (act_next_s[g]),
                .escape   (esc_s[g])
            );

            assign bus.BugH[g*W +: W] = h_s[g];
            assign bus.BugV[g*W +: W] = v_s[g] << V_SHIFT;
        end
    endgenerate

    assign act_pad_s = 8'(act_next_s);

    // Lane-wide status: escape/overflow pulses and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            escaped_r    <= 1'b0;
            overflow_r   <= 1'b0;
            live_count_r <= 4'd0;
        end else if (bus.INIT) begin
            escaped_r    <= 1'b0;
            overflow_r   <= 1'b0;
            live_count_r <= 4'd0;
        end else begin
            escaped_r    <= |esc_s;
            overflow_r   <= bus.spawn & ~any_free_s;
            live_count_r <= popcount(act_pad_s);
        end
    end

    assign bus.active     = act_s;
    assign bus.escaped    = escaped_r;
    assign bus.overflow   = overflow_r;
    assign bus.live_count = live_count_r;

endmodule

// File: tb/tb_bug_lane.sv
// Randomised and directed bench for bug_lane against a slot-level behavioural model.
module tb_bug_lane;

    localparam int NB      = 4;
    localparam int W       = 15;
    localparam int H_START = 640;
    localparam int H_STEP  = 1;
    localparam int V_MIN   = 40;
    localparam int V_MAX   = 220;
    localparam int V_STEP  = 1;

    logic clk;
    logic rst;

    bug_lane_if #(.NUM_BUGS(NB), .W(W)) bus ();

    bug_lane dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model of every slot, in plain integers.
    bit m_act [NB];
    int m_h   [NB];
    int m_v   [NB];
    int m_dir [NB];
    bit m_esc;
    bit m_ovf;
    int m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_act[i] = 1'b0; m_h[i] = 0; m_v[i] = 0; m_dir[i] = 0;
        end
        m_esc = 1'b0; m_ovf = 1'b0; m_cnt = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_clock();
        int slot;
        m_esc = 1'b0;
        m_ovf = 1'b0;
        if (bus.INIT) begin
            model_reset();
        end else begin
            slot = -1;
            if (bus.spawn) begin
                for (int i = 0; i < NB; i++)
                    if (slot < 0 && !m_act[i] && !bus.kill[i]) slot = i;
                if (slot < 0) m_ovf = 1'b1;
            end
            for (int i = 0; i < NB; i++) begin
                if (bus.kill[i]) begin
                    m_act[i] = 1'b0;
                end else if (i == slot) begin
                    m_act[i] = 1'b1;
                    m_h[i]   = H_START;
                    m_v[i]   = (bus.spawnV < V_MIN) ? V_MIN : (bus.spawnV > V_MAX) ? V_MAX : int'(bus.spawnV);
                    m_dir[i] = 0;
                end else if (bus.Frame && m_act[i]) begin
                    if (bus.leftEN) begin
                        if (m_h[i] < H_STEP) begin
                            m_act[i] = 1'b0;
                            m_esc    = 1'b1;
                        end else begin
                            m_h[i] = m_h[i] - H_STEP;
                        end
                    end
                    if (m_dir[i] == 0) begin
                        if (m_v[i] + V_STEP > V_MAX) begin m_v[i] = V_MAX; m_dir[i] = 1; end
                        else m_v[i] = m_v[i] + V_STEP;
                    end else begin
                        if (m_v[i] < V_MIN + V_STEP) begin m_v[i] = V_MIN; m_dir[i] = 0; end
                        else m_v[i] = m_v[i] - V_STEP;
                    end
                end
            end
            m_cnt = 0;
            for (int i = 0; i < NB; i++) m_cnt += int'(m_act[i]);
        end
    endtask

    task automatic compare_all();
        logic [NB-1:0] ea;
        for (int i = 0; i < NB; i++) ea[i] = m_act[i];
        check("active", bus.active, ea);
        check("escaped", bus.escaped, m_esc);
        check("overflow", bus.overflow, m_ovf);
        check("live_count", bus.live_count, m_cnt);
        for (int i = 0; i < NB; i++) begin
            if (m_act[i]) begin
                check($sformatf("bugh%0d", i), bus.BugH[i*W +: W], m_h[i]);
                check($sformatf("bugv%0d", i), bus.BugV[i*W +: W], (m_v[i] << 1) & 32'h7fff);
            end
        end
    endtask

    // One clock: edge, model update, compare on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_in(input bit i_init, input bit frm, input bit lft, input bit spn,
                          input int sv, input logic [NB-1:0] kl);
        bus.INIT   = i_init;
        bus.Frame  = frm;
        bus.leftEN = lft;
        bus.spawn  = spn;
        bus.spawnV = W'(sv);
        bus.kill   = kl;
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 0, 4'b0000);
        model_reset();
        @(negedge clk);
        compare_all();
        check("rst_bugh", bus.BugH, 60'd0);
        check("rst_bugv", bus.BugV, 60'd0);
        rst = 1'b0;
        cycle();

        // Spawn with spawnV=100.
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 100, 4'b0000);
        cycle();
        check("spawn_h0", bus.BugH[14:0], 15'd640);
        check("spawn_v0", bus.BugV[14:0], 15'd200);
        check("spawn_cnt", bus.live_count, 4'd1);

        // Walk to the left edge and escape.
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 0, 4'b0000);
        for (int k = 0; k < 638; k++) cycle();
        check("walk_h2", bus.BugH[14:0], 15'd2);
        cycle();
        check("walk_h1", bus.BugH[14:0], 15'd1);
        cycle();
        check("walk_h0", bus.BugH[14:0], 15'd0);
        cycle();
        check("escape_pulse", bus.escaped, 1'b1);
        check("escape_act0", bus.active[0], 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 0, 4'b0000);
        cycle();
        check("escape_single", bus.escaped, 1'b0);

        // Bounce at the lower and upper bounds.
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 219, 4'b0000);
        cycle();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 0, 4'b0000);
        cycle();
        check("bounce_max_a", bus.BugV[14:0], 15'd440);
        cycle();
        check("bounce_max_b", bus.BugV[14:0], 15'd440);
        cycle();
        check("bounce_max_c", bus.BugV[14:0], 15'd438);
        for (int k = 0; k < 179; k++) cycle();
        check("bounce_min_a", bus.BugV[14:0], 15'd80);
        cycle();
        cycle();
        check("bounce_min_b", bus.BugV[14:0], 15'd82);
        check("bounce_noh", bus.BugH[14:0], 15'd640);

        // Clear, then fill the lane and overflow.
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 0, 4'b0000);
        cycle();
        for (int k = 0; k < 5; k++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b1, int'($urandom_range(0, 300)), 4'b0000);
            cycle();
        end
        check("full_act", bus.active, 4'hf);
        check("full_ovf", bus.overflow, 1'b1);
        check("full_cnt", bus.live_count, 4'd4);

        // Kill and spawn together, then the next spawn reuses the slot.
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 50, 4'b0010);
        cycle();
        check("killspawn_ovf", bus.overflow, 1'b1);
        check("killspawn_act", bus.active, 4'b1101);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 60, 4'b0000);
        cycle();
        check("reuse_act", bus.active, 4'hf);
        check("reuse_h1", bus.BugH[29:15], 15'd640);

        // Spawn coincident with a frame lands unmoved.
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 0, 4'b0100);
        cycle();
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 70, 4'b0000);
        cycle();
        check("spawnframe_h2", bus.BugH[44:30], 15'd640);
        check("spawnframe_h0", bus.BugH[14:0], 15'd639);

        // INIT during motion.
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 0, 4'b0000);
        cycle();
        check("init_act", bus.active, 4'h0);
        check("init_esc", bus.escaped, 1'b0);
        check("init_bugh", bus.BugH, 60'd0);
        check("init_bugv", bus.BugV, 60'd0);

        // Randomised traffic.
        for (int k = 0; k < 3000; k++) begin
            set_in(($urandom_range(0, 199) == 0),
                   ($urandom_range(0, 1) == 1),
                   ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 4) < 2),
                   int'($urandom_range(0, 300)),
                   {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)});
            cycle();
        end

        // Asynchronous reset between edges.
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 120, 4'b0000);
        cycle();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 0, 4'b0000);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst_act", bus.active, 4'h0);
        check("arst_bugh", bus.BugH, 60'd0);
        check("arst_bugv", bus.BugV, 60'd0);
        check("arst_cnt", bus.live_count, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 10, 4'b0000);
        cycle();
        check("post_rst_v0", bus.BugV[14:0], 15'd80);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
